// File: rtl/alu_arbiter_pkg.sv
// Shared constants and helpers for the two-port ALU arbiter.
// Opcode encodings match the shared ALU.
package alu_arbiter_pkg;

    localparam logic [3:0] ALUADD  = 4'd0;
    localparam logic [3:0] ALUSUB  = 4'd1;
    localparam logic [3:0] ALUAND  = 4'd2;
    localparam logic [3:0] ALUOR   = 4'd3;
    localparam logic [3:0] ALUXOR  = 4'd4;
    localparam logic [3:0] ALUSLT  = 4'd5;
    localparam logic [3:0] ALUSLTU = 4'd6;
    localparam logic [3:0] ALUSLL  = 4'd7;
    localparam logic [3:0] ALUSRL  = 4'd8;
    localparam logic [3:0] ALUSRA  = 4'd9;

    localparam logic ARB_REQ0     = 1'b0;
    localparam logic ARB_REQ1     = 1'b1;
    localparam logic ARB_RST_LAST = ARB_REQ1;

    typedef struct packed {
        logic vld;
        logic idx;
    } grant_t;

    // Round-robin pick: on a tie the requester that did not win last time goes.
    function automatic grant_t pick_grant(
        input logic e0,
        input logic e1,
        input logic last
    );
        grant_t g;
        g.vld = e0 | e1;
        if (e0 && e1) begin
            g.idx = ~last;
        end else if (e1) begin
            g.idx = ARB_REQ1;
        end else begin
            g.idx = ARB_REQ0;
        end
        return g;
    endfunction

endpackage

// File: rtl/alu_arbiter_rsp.sv
// One-entry registered response buffer with valid/ready drain.
// A slot can be drained and reloaded in the same cycle.
module alu_rsp_slot
    import alu_arbiter_pkg::*;
#(
    parameter int VAR_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [VAR_WIDTH-1:0] load_data,
    output logic                 valid,
    output logic [VAR_WIDTH-1:0] data,
    input  logic                 ready,
    output logic                 free
);

    logic                 valid_q, valid_d;
    logic [VAR_WIDTH-1:0] data_q, data_d;

    assign free  = ~valid_q | ready;
    assign valid = valid_q;
    assign data  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two
// requesters, with a registered one-entry response slot per requester.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int VAR_WIDTH = 32,
    parameter int OP_WIDTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [OP_WIDTH-1:0]  req0_opcode,
    input  logic [VAR_WIDTH-1:0] req0_a,
    input  logic [VAR_WIDTH-1:0] req0_b,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [OP_WIDTH-1:0]  req1_opcode,
    input  logic [VAR_WIDTH-1:0] req1_a,
    input  logic [VAR_WIDTH-1:0] req1_b,
    output logic                 rsp0_valid,
    output logic [VAR_WIDTH-1:0] rsp0_data,
    input  logic                 rsp0_ready,
    output logic                 rsp1_valid,
    output logic [VAR_WIDTH-1:0] rsp1_data,
    input  logic                 rsp1_ready,
    output logic [OP_WIDTH-1:0]  alu_opcode,
    output logic [VAR_WIDTH-1:0] alu_a,
    output logic [VAR_WIDTH-1:0] alu_b,
    input  logic [VAR_WIDTH-1:0] alu_out
);

    logic   free0, free1;
    logic   elig0, elig1;
    grant_t gnt;
    logic   last_grant_q, last_grant_d;

    // Nothing is accepted while reset is held.
    assign elig0 = req0_valid & free0 & ~rst;
    assign elig1 = req1_valid & free1 & ~rst;

    always_comb begin
        gnt = pick_grant(elig0, elig1, last_grant_q);
    end

    assign req0_ready = gnt.vld & (gnt.idx == ARB_REQ0);
    assign req1_ready = gnt.vld & (gnt.idx == ARB_REQ1);

    always_comb begin
        alu_opcode = '0;
        alu_a      = '0;
        alu_b      = '0;
        if (req1_ready) begin
            alu_opcode = req1_opcode;
            alu_a      = req1_a;
            alu_b      = req1_b;
        end else if (req0_ready) begin
            alu_opcode = req0_opcode;
            alu_a      = req0_a;
            alu_b      = req0_b;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (gnt.vld) begin
            last_grant_d = gnt.idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= ARB_RST_LAST;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    alu_rsp_slot #(
        .VAR_WIDTH(VAR_WIDTH)
    ) u_slot0 (
        .clk      (clk),
        .rst      (rst),
        .load     (req0_ready),
        .load_data(alu_out),
        .valid    (rsp0_valid),
        .data     (rsp0_data),
        .ready    (rsp0_ready),
        .free     (free0)
    );

    alu_rsp_slot #(
        .VAR_WIDTH(VAR_WIDTH)
    ) u_slot1 (
        .clk      (clk),
        .rst      (rst),
        .load     (req1_ready),
        .load_data(alu_out),
        .valid    (rsp1_valid),
        .data     (rsp1_data),
        .ready    (rsp1_ready),
        .free     (free1)
    );

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic
// against a transaction-level model of the two slots and round-robin.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        v[2];
    logic [3:0]  op[2];
    logic [31:0] a[2];
    logic [31:0] b[2];
    logic        rr[2];

    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_data, rsp1_data;
    logic [3:0]  alu_opcode;
    logic [31:0] alu_a, alu_b, alu_out;

    int checks = 0;
    int errors = 0;

    // model state
    bit          mv[2];
    logic [31:0] md[2];
    int          mlast;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(
        input logic [3:0]  o,
        input logic [31:0] x,
        input logic [31:0] y
    );
        case (o)
            ALUADD:  return x + y;
            ALUSUB:  return x - y;
            ALUAND:  return x & y;
            ALUOR:   return x | y;
            ALUXOR:  return x ^ y;
            ALUSLT:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            ALUSLTU: return (x < y) ? 32'd1 : 32'd0;
            ALUSLL:  return x << y[4:0];
            ALUSRL:  return x >> y[4:0];
            ALUSRA:  return $unsigned($signed(x) >>> y[4:0]);
            default: return 32'd0;
        endcase
    endfunction

    // Stand-in for the shared combinational ALU.
    assign alu_out = alu_ref(alu_opcode, alu_a, alu_b);

    alu_arbiter #(
        .VAR_WIDTH(32),
        .OP_WIDTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (v[0]),
        .req0_ready (req0_ready),
        .req0_opcode(op[0]),
        .req0_a     (a[0]),
        .req0_b     (b[0]),
        .req1_valid (v[1]),
        .req1_ready (req1_ready),
        .req1_opcode(op[1]),
        .req1_a     (a[1]),
        .req1_b     (b[1]),
        .rsp0_valid (rsp0_valid),
        .rsp0_data  (rsp0_data),
        .rsp0_ready (rr[0]),
        .rsp1_valid (rsp1_valid),
        .rsp1_data  (rsp1_data),
        .rsp1_ready (rr[1]),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_out    (alu_out)
    );

    // Which requester the rules say wins this cycle; -1 for none.
    function automatic int exp_grant();
        bit e[2];
        if (rst) return -1;
        for (int n = 0; n < 2; n++) begin
            e[n] = v[n] && (!mv[n] || rr[n]);
        end
        if (e[0] && e[1]) return (mlast == 0) ? 1 : 0;
        if (e[0]) return 0;
        if (e[1]) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        mv[0] = 0;
        mv[1] = 0;
        md[0] = 32'd0;
        md[1] = 32'd0;
        mlast = 1;
    endtask

    task automatic model_adv(input int g);
        if (rst) begin
            model_reset();
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (g == n) begin
                    mv[n] = 1;
                    md[n] = alu_ref(op[n], a[n], b[n]);
                end else if (mv[n] && rr[n]) begin
                    mv[n] = 0;
                end
            end
            if (g >= 0) mlast = g;
        end
    endtask

    task automatic idle();
        for (int n = 0; n < 2; n++) begin
            v[n]  = 1'b0;
            op[n] = 4'd0;
            a[n]  = 32'd0;
            b[n]  = 32'd0;
            rr[n] = 1'b1;
        end
    endtask

    task automatic set_req(
        input int          n,
        input logic [3:0]  o,
        input logic [31:0] x,
        input logic [31:0] y
    );
        v[n]  = 1'b1;
        op[n] = o;
        a[n]  = x;
        b[n]  = y;
    endtask

    // End the current cycle: update the model and step to the next one.
    task automatic finish_cycle();
        model_adv(exp_grant());
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        @(negedge clk);
        finish_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        set_req(0, ALUADD, 32'd1, 32'd2);
        set_req(1, ALUADD, 32'd3, 32'd4);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if ({req0_ready, req1_ready} !== 2'b00) begin
                errors++;
                $display("FAIL reset_ready c%0d got %b%b want 00",
                         c, req0_ready, req1_ready);
            end
            checks++;
            if ({alu_opcode, alu_a, alu_b} !== 68'd0) begin
                errors++;
                $display("FAIL reset_alu c%0d got %h %h %h want 0",
                         c, alu_opcode, alu_a, alu_b);
            end
            if (c == 1) begin
                checks++;
                if ({rsp0_valid, rsp1_valid} !== 2'b00 ||
                    rsp0_data !== 32'd0 || rsp1_data !== 32'd0) begin
                    errors++;
                    $display("FAIL reset_rsp got v%b%b d%h %h want 0",
                             rsp0_valid, rsp1_valid, rsp0_data, rsp1_data);
                end
            end
            finish_cycle();
        end
        rst = 1'b0;
        idle();
    endtask

    task automatic test_single();
        idle();
        set_req(0, ALUADD, 32'd5, 32'd7);
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1 || alu_a !== 32'd5 ||
            alu_b !== 32'd7 || alu_opcode !== ALUADD) begin
            errors++;
            $display("FAIL single_accept got rdy=%b alu=%h %h %h want 1 0 5 7",
                     req0_ready, alu_opcode, alu_a, alu_b);
        end
        finish_cycle();
        idle();
        @(negedge clk);
        checks++;
        if (rsp0_valid !== 1'b1 || rsp0_data !== 32'd12) begin
            errors++;
            $display("FAIL single_rsp got v=%b d=%0d want 1 12",
                     rsp0_valid, rsp0_data);
        end
        finish_cycle();
        @(negedge clk);
        checks++;
        if (rsp0_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drain got v=%b want 0", rsp0_valid);
        end
        finish_cycle();
    endtask

    task automatic test_alternate();
        do_reset();
        set_req(0, ALUSUB, 32'd10, 32'd3);
        set_req(1, ALUXOR, 32'hF0, 32'h0F);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (req0_ready !== (c % 2 == 0) || req1_ready !== (c % 2 == 1)) begin
                errors++;
                $display("FAIL alt_grant c%0d got %b%b want %0d",
                         c, req0_ready, req1_ready, c % 2);
            end
            if (c >= 2) begin
                checks++;
                if (rsp0_data !== 32'd7 || rsp1_data !== 32'hFF) begin
                    errors++;
                    $display("FAIL alt_data c%0d got %h %h want 7 ff",
                             c, rsp0_data, rsp1_data);
                end
            end
            finish_cycle();
        end
        idle();
    endtask

    task automatic test_hol();
        do_reset();
        set_req(0, ALUADD, 32'd1, 32'd2);
        rr[0] = 1'b0;
        @(negedge clk);
        finish_cycle();
        set_req(0, ALUADD, 32'd3, 32'd4);
        set_req(1, ALUSLT, 32'hFFFF_FFFF, 32'd1);
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL hol_grant got %b%b want 01",
                     req0_ready, req1_ready);
        end
        finish_cycle();
        v[1]  = 1'b0;
        rr[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (rsp1_valid !== 1'b1 || rsp1_data !== 32'd1) begin
            errors++;
            $display("FAIL hol_slt got v=%b d=%h want 1 1",
                     rsp1_valid, rsp1_data);
        end
        checks++;
        if (req0_ready !== 1'b1 || rsp0_data !== 32'd3) begin
            errors++;
            $display("FAIL hol_refill got rdy=%b d=%0d want 1 3",
                     req0_ready, rsp0_data);
        end
        finish_cycle();
        idle();
        @(negedge clk);
        checks++;
        if (rsp0_valid !== 1'b1 || rsp0_data !== 32'd7) begin
            errors++;
            $display("FAIL hol_after got v=%b d=%0d want 1 7",
                     rsp0_valid, rsp0_data);
        end
        finish_cycle();
    endtask

    task automatic test_back_to_back();
        idle();
        set_req(1, ALUSLL, 32'd1, 32'd4);
        @(negedge clk);
        checks++;
        if (req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first got rdy=%b want 1", req1_ready);
        end
        finish_cycle();
        set_req(1, ALUSRA, 32'h8000_0000, 32'd4);
        @(negedge clk);
        checks++;
        if (req1_ready !== 1'b1 || rsp1_valid !== 1'b1 ||
            rsp1_data !== 32'd16) begin
            errors++;
            $display("FAIL b2b_sll got rdy=%b v=%b d=%h want 1 1 10",
                     req1_ready, rsp1_valid, rsp1_data);
        end
        finish_cycle();
        idle();
        @(negedge clk);
        checks++;
        if (rsp1_valid !== 1'b1 || rsp1_data !== 32'hF800_0000) begin
            errors++;
            $display("FAIL b2b_sra got v=%b d=%h want 1 f8000000",
                     rsp1_valid, rsp1_data);
        end
        finish_cycle();
    endtask

    task automatic test_reset_mid();
        idle();
        set_req(0, ALUADD, 32'd1, 32'd1);
        @(negedge clk);
        finish_cycle();
        idle();
        set_req(1, ALUADD, 32'd9, 32'd9);
        rst = 1'b1;
        @(negedge clk);
        finish_cycle();
        rst = 1'b0;
        idle();
        set_req(0, ALUOR, 32'd2, 32'd4);
        set_req(1, ALUOR, 32'd8, 32'd1);
        @(negedge clk);
        checks++;
        if (rsp1_valid !== 1'b0 || rsp1_data !== 32'd0 ||
            rsp0_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_rsp got v=%b%b d1=%h want 00 0",
                     rsp0_valid, rsp1_valid, rsp1_data);
        end
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_tie got %b%b want 10",
                     req0_ready, req1_ready);
        end
        finish_cycle();
        idle();
        @(negedge clk);
        finish_cycle();
    endtask

    task automatic test_random();
        int g;
        logic [3:0]  eo;
        logic [31:0] ea, eb;
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 60) == 0);
            for (int n = 0; n < 2; n++) begin
                v[n]  = ($urandom_range(0, 3) != 0);
                op[n] = 4'($urandom_range(0, 15));
                a[n]  = $urandom;
                b[n]  = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40));
                rr[n] = ($urandom_range(0, 2) != 0);
            end
            @(negedge clk);
            g = exp_grant();
            checks++;
            if (req0_ready !== (g == 0) || req1_ready !== (g == 1)) begin
                errors++;
                $display("FAIL rnd_grant c%0d got %b%b want %0d",
                         c, req0_ready, req1_ready, g);
            end
            eo = (g >= 0) ? op[g] : 4'd0;
            ea = (g >= 0) ? a[g] : 32'd0;
            eb = (g >= 0) ? b[g] : 32'd0;
            checks++;
            if (alu_opcode !== eo || alu_a !== ea || alu_b !== eb) begin
                errors++;
                $display("FAIL rnd_alu c%0d got %h %h %h want %h %h %h",
                         c, alu_opcode, alu_a, alu_b, eo, ea, eb);
            end
            checks++;
            if (rsp0_valid !== mv[0] || rsp0_data !== md[0] ||
                rsp1_valid !== mv[1] || rsp1_data !== md[1]) begin
                errors++;
                $display("FAIL rnd_rsp c%0d got %b %h %b %h want %b %h %b %h",
                         c, rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
                         mv[0], md[0], mv[1], md[1]);
            end
            finish_cycle();
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        model_reset();
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_alternate();
        test_hol();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
